// File: rtl/soc_mem_pkg.sv
// Shared helpers for the multiport SoC memory and its arbiter.
// Widths are derived from the owning module's parameters.
package soc_mem_pkg;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int word_addr_width(input int addr_width, input int data_width);
    return addr_width - $clog2(data_width / 8);
  endfunction

  // Port ids keep at least one bit so the single-port build still has a legal type.
  function automatic int port_id_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/soc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// The pointer moves past the winner only when advance_i is high.
module soc_rr_arbiter
  import soc_mem_pkg::*;
#(
  parameter int N  = 2,
  localparam int IW = port_id_width(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] winner_o,
  output logic          valid_o
);

  logic [IW-1:0] ptr_q, ptr_d;

  // Two passes: ports at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    gnt_o    = '0;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!valid_o && req_i[j] && (IW'(j) >= ptr_q)) begin
        gnt_o[j] = 1'b1;
        winner_o = IW'(j);
        valid_o  = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!valid_o && req_i[j] && (IW'(j) < ptr_q)) begin
        gnt_o[j] = 1'b1;
        winner_o = IW'(j);
        valid_o  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && valid_o) begin
      if (int'(winner_o) == N - 1) ptr_d = '0;
      else                         ptr_d = winner_o + IW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/soc_memory_multiport.sv
// Shared block RAM with round-robin access from NUM_PORTS requestors.
// Read-first, byte-enable writes, fixed-latency response pipeline with per-port valid.
module soc_memory_multiport
  import soc_mem_pkg::*;
#(
  parameter int    ADDR_WIDTH    = 12,
  parameter int    DATA_WIDTH    = 32,
  parameter int    NUM_PORTS     = 2,
  parameter int    LATENCY       = 1,
  parameter string MEM_INIT_FILE = "none"
) (
  input  logic                                 clk,
  input  logic                                 res,
  input  logic [NUM_PORTS-1:0]                 req,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]  we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]      wdata,
  output logic [NUM_PORTS-1:0]                 gnt,
  output logic [NUM_PORTS-1:0]                 rvalid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]      rdata
);

  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int OFF   = $clog2(BPW);
  localparam int WAW   = word_addr_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int DEPTH = 1 << WAW;
  localparam int IW    = port_id_width(NUM_PORTS);

  typedef logic [IW-1:0] port_id_t;
  typedef struct packed {
    logic                  valid;
    port_id_t              port;
    logic [DATA_WIDTH-1:0] data;
  } resp_stage_t;

  if (DATA_WIDTH < 8 || DATA_WIDTH > 128 || (DATA_WIDTH % 8) != 0 ||
      (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_dw
    $error("soc_memory_multiport: DATA_WIDTH must be a power of two in 8..128");
  end
  if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_np
    $error("soc_memory_multiport: NUM_PORTS must be in 1..8");
  end
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_lat
    $error("soc_memory_multiport: LATENCY must be in 1..4");
  end
  if (ADDR_WIDTH <= OFF) begin : g_bad_aw
    $error("soc_memory_multiport: ADDR_WIDTH too small for DATA_WIDTH");
  end

  logic [NUM_PORTS-1:0]  arb_gnt;
  port_id_t              winner;
  logic                  arb_valid;
  logic                  acc;
  logic [WAW-1:0]        sel_word;
  logic [BPW-1:0]        sel_we;
  logic [DATA_WIDTH-1:0] sel_wdata;

  soc_rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk_i     (clk),
    .rst_ni    (res),
    .req_i     (req),
    .advance_i (res),
    .gnt_o     (arb_gnt),
    .winner_o  (winner),
    .valid_o   (arb_valid)
  );

  // Grant is masked by reset so nothing is accepted while res is low.
  always_comb begin
    gnt       = res ? arb_gnt : '0;
    acc       = res && arb_valid;
    sel_word  = addr[int'(winner)*ADDR_WIDTH + OFF +: WAW];
    sel_we    = we[int'(winner)*BPW +: BPW];
    sel_wdata = wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      for (int b = 0; b < BPW; b++) begin
        if (sel_we[b]) mem[sel_word][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  resp_stage_t pipe_q [LATENCY];
  resp_stage_t pipe_d [LATENCY];
  resp_stage_t resp;

  // Stage 0 samples the pre-write word at the acceptance edge (read-first).
  always_comb begin
    pipe_d[0] = '{valid: acc, port: winner, data: mem[sel_word]};
    for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  always_comb begin
    resp   = pipe_q[LATENCY-1];
    rvalid = '0;
    rdata  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (resp.valid && resp.port == port_id_t'(k)) begin
        rvalid[k]                         = 1'b1;
        rdata[k*DATA_WIDTH +: DATA_WIDTH] = resp.data;
      end
    end
  end

endmodule

// File: tb/tb_soc_memory_multiport.sv
// Directed bench for soc_memory_multiport: reference arbiter/memory model feeds a
// response scoreboard that is checked every cycle on the falling edge.
module tb_soc_memory_multiport;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int NP  = 2;
  localparam int LAT = 2;
  localparam int BPW = DW / 8;

  logic              clk   = 1'b0;
  logic              res   = 1'b1;
  logic [NP-1:0]     req   = '0;
  logic [NP*BPW-1:0] we    = '0;
  logic [NP*AW-1:0]  addr  = '0;
  logic [NP*DW-1:0]  wdata = '0;
  logic [NP-1:0]     gnt;
  logic [NP-1:0]     rvalid;
  logic [NP*DW-1:0]  rdata;

  always #5 clk = ~clk;

  soc_memory_multiport #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .NUM_PORTS     (NP),
    .LATENCY       (LAT),
    .MEM_INIT_FILE ("none")
  ) dut (
    .clk    (clk),
    .res    (res),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .gnt    (gnt),
    .rvalid (rvalid),
    .rdata  (rdata)
  );

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ptr = 0;
  int          gcnt[NP];
  logic [31:0] mdl[1024];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response checker: exactly the scheduled response (or nothing) on every cycle.
  always @(negedge clk) begin
    logic [NP-1:0]    ev;
    logic [NP*DW-1:0] ed;
    ev = '0;
    ed = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      ev = NP'(1) << sb[0].port;
      ed = (NP*DW)'(sb[0].data) << (DW * sb[0].port);
      void'(sb.pop_front());
    end
    check("rvalid", 64'(rvalid), 64'(ev));
    check("rdata", 64'(rdata), 64'(ed));
  end

  task automatic drive(input int p, input logic [AW-1:0] a, input logic [BPW-1:0] e,
                       input logic [DW-1:0] d);
    addr[p*AW +: AW]    = a;
    we[p*BPW +: BPW]    = e;
    wdata[p*DW +: DW]   = d;
  endtask

  // Called at negedge+1 with inputs already set; ends at the next negedge+1.
  task automatic step(output int won);
    int          w;
    int          wa;
    logic [31:0] word;
    w = -1;
    #1;
    if (res) begin
      for (int i = 0; i < NP; i++) begin
        int j;
        j = (ptr + i) % NP;
        if (w < 0 && req[j]) w = j;
      end
    end
    check("gnt", 64'(gnt), (w >= 0) ? (64'd1 << w) : 64'd0);
    for (int k = 0; k < NP; k++) if (gnt[k] === 1'b1) gcnt[k]++;
    if (w >= 0) begin
      wa   = int'(addr[w*AW + 2 +: AW-2]);
      word = mdl[wa];
      sb.push_back('{port: w, data: word, due: cyc + LAT});
      for (int b = 0; b < BPW; b++)
        if (we[w*BPW + b]) word[b*8 +: 8] = wdata[w*DW + b*8 +: 8];
      mdl[wa] = word;
      ptr     = (w + 1) % NP;
    end
    won = w;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    int w;
    req = '0;
    for (int i = 0; i < n; i++) step(w);
  endtask

  initial begin
    int          w;
    logic [31:0] d0, d1;
    for (int i = 0; i < 1024; i++) mdl[i] = '0;
    for (int k = 0; k < NP; k++) gcnt[k] = 0;

    #1 res = 1'b0;
    @(negedge clk); #1;
    // Requests during reset must never be granted.
    req = 2'b11;
    step(w);
    step(w);
    req = '0;
    res = 1'b1;
    idle(10);

    // Fairness from reset: both ports write continuously, new data after each grant.
    for (int k = 0; k < NP; k++) gcnt[k] = 0;
    d0 = 32'hA000_0000;
    d1 = 32'hB000_0000;
    drive(0, 12'h040, 4'hF, d0);
    drive(1, 12'h080, 4'hF, d1);
    req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      step(w);
      if (w == 0) begin d0 = d0 + 1; drive(0, 12'h040, 4'hF, d0); end
      if (w == 1) begin d1 = d1 + 1; drive(1, 12'h080, 4'hF, d1); end
    end
    check("fair_port0", 64'(gcnt[0]), 64'd4);
    check("fair_port1", 64'(gcnt[1]), 64'd4);
    idle(LAT + 1);

    // Single port write then read.
    req = 2'b01;
    drive(0, 12'h010, 4'hF, 32'hDEAD_BEEF);
    step(w);
    drive(0, 12'h010, 4'h0, 32'h0);
    step(w);
    idle(LAT + 1);

    // Byte enables, read-first, read right after write.
    req = 2'b01;
    drive(0, 12'h020, 4'hF, 32'h1122_3344);
    step(w);
    drive(0, 12'h020, 4'h3, 32'hAABB_CCDD);
    step(w);
    drive(0, 12'h020, 4'h0, 32'h0);
    step(w);
    idle(LAT + 1);

    // Lone port 1 with pointer at 1, then at 0 (wrapped search), then contention.
    req = 2'b10;
    drive(1, 12'h020, 4'h0, 32'h0);
    step(w);
    step(w);
    req = 2'b11;
    drive(0, 12'h010, 4'h0, 32'h0);
    step(w);
    step(w);
    idle(LAT + 1);

    // Misaligned byte write, aligned read, last word independent.
    req = 2'b01;
    drive(0, 12'h003, 4'h1, 32'h0000_0055);
    step(w);
    drive(0, 12'h000, 4'h0, 32'h0);
    step(w);
    req = 2'b10;
    drive(1, 12'hFFC, 4'h0, 32'h0);
    step(w);
    drive(1, 12'hFFE, 4'hF, 32'h1234_5678);
    step(w);
    req = 2'b01;
    step(w);
    req = 2'b10;
    drive(1, 12'hFFC, 4'h0, 32'h0);
    step(w);
    idle(LAT + 1);

    // Reset one cycle after a granted read: its response must vanish.
    req = 2'b01;
    drive(0, 12'h010, 4'h0, 32'h0);
    step(w);
    req = '0;
    res = 1'b0;
    sb.delete();
    ptr = 0;
    idle(3);
    res = 1'b1;
    idle(2);
    req = 2'b01;
    step(w);
    idle(LAT + 2);

    check("drain", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
